// File: rtl/seq_detect_scheduler_pkg.sv
// rtl/seq_detect_scheduler_pkg.sv - symbol/state encodings and the shared 1-2-3 transition function
package seq_detect_scheduler_pkg;

  typedef enum logic [1:0] {
    SYM_NOP = 2'd0,
    SYM_A   = 2'd1,
    SYM_B   = 2'd2,
    SYM_C   = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_AB   = 2'd2,
    ST_ABC  = 2'd3
  } st_t;

  // NOP holds; an A always restarts the sequence, whatever was seen before.
  function automatic st_t next_state(input st_t s, input sym_t y);
    st_t n;
    n = s;
    case (y)
      SYM_NOP: n = s;
      SYM_A:   n = ST_A;
      SYM_B:   n = (s == ST_A || s == ST_AB) ? ST_AB : ST_IDLE;
      SYM_C:   n = (s == ST_AB || s == ST_ABC) ? ST_ABC : ST_IDLE;
      default: n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// rtl/seq_detect_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module seq_detect_scheduler_rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - one shared 1-2-3 detector time-multiplexed over N_CH symbol streams
module seq_detect_scheduler
  import seq_detect_scheduler_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     req_valid,
  input  logic [2*N_CH-1:0]   req_sym,
  output logic [N_CH-1:0]     req_ready,
  input  logic [N_CH-1:0]     ctx_clr,
  output logic [N_CH-1:0]     match,
  output logic                hit,
  output logic [CH_W-1:0]     hit_ch,
  output logic [CNT_W-1:0]    hit_total
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0] ptr;
  st_t             state [N_CH];

  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] g_idx;
  logic            g_any;
  sym_t            g_sym;
  st_t             g_state;
  st_t             g_next;
  logic            hit_now;

  // A channel being cleared is held off so its pending symbol lands on the cleared state.
  assign eligible = req_valid & ~ctx_clr;

  seq_detect_scheduler_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign req_ready = reset_n ? grant : '0;
  assign g_sym     = sym_t'(req_sym[2*g_idx +: 2]);
  assign g_state   = state[g_idx];
  assign g_next    = next_state(g_state, g_sym);
  assign hit_now   = g_any && (g_state != ST_ABC) && (g_next == ST_ABC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= '0;
      hit       <= 1'b0;
      hit_ch    <= '0;
      hit_total <= '0;
      for (int i = 0; i < N_CH; i++) state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ctx_clr[i])    state[i] <= ST_IDLE;
        else if (grant[i]) state[i] <= g_next;
      end
      if (g_any) ptr <= (g_idx == LAST_CH) ? '0 : g_idx + CH_W'(1);
      hit <= hit_now;
      if (hit_now) begin
        hit_ch    <= g_idx;
        hit_total <= hit_total + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_match
      assign match[gi] = (state[gi] == ST_ABC);
    end
  endgenerate

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - scoreboard bench for seq_detect_scheduler
module tb_seq_detect_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [7:0] req_sym = '0;
  logic [3:0] req_ready;
  logic [3:0] ctx_clr = '0;
  logic [3:0] match;
  logic       hit;
  logic [1:0] hit_ch;
  logic [7:0] hit_total;

  int checks = 0;
  int errors = 0;

  int exp_grant[$];
  int exp_hit_ch[$];
  int exp_hit_tot[$];

  logic [3:0] ready_seen;
  logic [3:0] hs;
  int         g_got;
  int         g_exp;

  seq_detect_scheduler #(.N_CH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_sym   (req_sym),
    .req_ready (req_ready),
    .ctx_clr   (ctx_clr),
    .match     (match),
    .hit       (hit),
    .hit_ch    (hit_ch),
    .hit_total (hit_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and every hit pulse.
  always @(negedge clk) begin
    checks++;
    if (((req_ready & ~req_valid) != 0) || !$onehot0(req_ready)) begin
      errors++;
      $display("FAIL ready_legal actual=%b valid=%b", req_ready, req_valid);
    end
    hs = req_valid & req_ready;
    if (hs != 0) begin
      g_got = 0;
      for (int i = 0; i < 4; i++) if (hs[i]) g_got = i;
      if (exp_grant.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected actual=%0d expected=none", g_got);
      end else begin
        g_exp = exp_grant.pop_front();
        check("grant_ch", g_got, g_exp);
      end
    end
    if (hit === 1'b1) begin
      if (exp_hit_ch.size() == 0) begin
        checks++; errors++;
        $display("FAIL hit_unexpected actual_ch=%0d expected=none", hit_ch);
      end else begin
        check("hit_ch", int'(hit_ch), exp_hit_ch.pop_front());
        check("hit_total", int'(hit_total), exp_hit_tot.pop_front());
      end
    end
  end

  // One cycle of stimulus; g < 0 means no grant expected, hch < 0 means no hit expected.
  task automatic step(input logic [3:0] v, input logic [7:0] s, input logic [3:0] c,
                      input int g, input int hch, input int htot);
    req_valid = v;
    req_sym   = s;
    ctx_clr   = c;
    if (g >= 0) exp_grant.push_back(g);
    if (hch >= 0) begin
      exp_hit_ch.push_back(hch);
      exp_hit_tot.push_back(htot);
    end
    #1 ready_seen = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 4'hF;
    req_sym   = 8'hFF;
    ctx_clr   = '0;
    #1 check("reset_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    check("reset_hit", int'(hit), 0);
    check("reset_hit_ch", int'(hit_ch), 0);
    check("reset_total", int'(hit_total), 0);
    check("reset_match", int'(match), 0);
    reset_n   = 1'b1;
    req_valid = '0;
    req_sym   = '0;
  endtask

  int t1_sym[7]   = '{1, 2, 1, 2, 3, 3, 1};
  int t1_match[7] = '{0, 0, 0, 0, 1, 1, 0};

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Channel 0 alone: 1,2,1,2,3,3,1
    for (int k = 0; k < 7; k++) begin
      step(4'b0001, 8'(t1_sym[k]), 4'b0, 0, (k == 4) ? 0 : -1, 1);
      check("t1_match0", int'(match[0]), t1_match[k]);
    end
    check("t1_total", int'(hit_total), 1);

    // All four channels streaming 1,2,3 in rotation
    do_reset();
    for (int k = 0; k < 12; k++) begin
      logic [7:0] rs;
      rs = (k < 4) ? 8'h55 : (k < 8) ? 8'hAA : 8'hFF;
      step(4'hF, rs, 4'b0, k % 4, (k >= 8) ? k - 8 : -1, k - 7);
    end
    check("t2_match", int'(match), 15);
    check("t2_total", int'(hit_total), 4);

    // Channels 1 and 3 with ptr at 2
    do_reset();
    step(4'b0010, 8'h00, 4'b0, 1, -1, 0);
    step(4'b1010, 8'h00, 4'b0, 3, -1, 0);
    step(4'b1010, 8'h00, 4'b0, 1, -1, 0);

    // Clear channel 2 while its completing 3 is pending
    do_reset();
    step(4'b0100, 8'h10, 4'b0, 2, -1, 0);
    step(4'b0100, 8'h20, 4'b0, 2, -1, 0);
    step(4'b0100, 8'h30, 4'b0100, -1, -1, 0);
    check("t4_clr_ready", int'(ready_seen), 0);
    step(4'b0100, 8'h30, 4'b0, 2, -1, 0);
    check("t4_ready", int'(ready_seen), 4);
    check("t4_match", int'(match), 0);
    check("t4_total", int'(hit_total), 0);

    // 256 sequences on channel 1 wrap the counter
    do_reset();
    for (int n = 0; n < 256; n++) begin
      step(4'b0010, 8'h04, 4'b0, 1, -1, 0);
      step(4'b0010, 8'h08, 4'b0, 1, -1, 0);
      step(4'b0010, 8'h0C, 4'b0, 1, 1, (n + 1) % 256);
      if (n == 254) check("t5_total_255", int'(hit_total), 255);
    end
    check("t5_total_wrap", int'(hit_total), 0);
    check("t5_match", int'(match), 2);

    // Reset arriving with channel 0 at state 2 and a 3 pending
    do_reset();
    step(4'b0001, 8'h01, 4'b0, 0, -1, 0);
    step(4'b0001, 8'h02, 4'b0, 0, -1, 0);
    reset_n = 1'b0;
    step(4'b0001, 8'h03, 4'b0, -1, -1, 0);
    check("t6_rst_ready", int'(ready_seen), 0);
    check("t6_rst_hit", int'(hit), 0);
    check("t6_rst_match", int'(match), 0);
    check("t6_rst_total", int'(hit_total), 0);
    reset_n = 1'b1;
    step(4'b0011, 8'h03, 4'b0, 0, -1, 0);
    check("t6_ready", int'(ready_seen), 1);
    check("t6_match", int'(match), 0);

    step(4'b0000, 8'h00, 4'b0, -1, -1, 0);
    step(4'b0000, 8'h00, 4'b0, -1, -1, 0);
    step(4'b0000, 8'h00, 4'b0, -1, -1, 0);
    check("left_grants", exp_grant.size(), 0);
    check("left_hits", exp_hit_ch.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Shares one 1-2-3 sequence-detector transition function between N_CH symbol streams. Each requester presents 2-bit symbols over a valid/ready handshake. A round-robin arbiter grants one stream per cycle. The block keeps a saved detector state per channel, applies the granted symbol to that channel's state, and reports completed-sequence hits tagged with the channel id.

Parameters:
N_CH, 4, number of requester channels (2..8)
CH_W, $clog2(N_CH), width of channel id (derived, not overridden)
CNT_W, 8, width of global hit counter

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
req_valid  in  N_CH  channel i has a symbol pending
req_sym  in  2*N_CH  symbol of channel i at bits [2i+1:2i]
req_ready  out  N_CH  one-hot (or zero) grant; symbol consumed when valid&ready
ctx_clr  in  N_CH  per-channel pulse: clear saved state to 0
match  out  N_CH  level: channel i saved state == 3
hit  out  1  registered pulse: a channel just entered state 3
hit_ch  out  CH_W  channel that produced hit
hit_total  out  CNT_W  count of hit pulses since reset

Behaviour:
- Reset (reset_n=0 at posedge): all saved states=0; rr pointer=0; hit=0; hit_ch=0; hit_total=0. Therefore match=0. req_ready=0 while reset_n=0.
- Eligible(i) = req_valid[i] & ~ctx_clr[i].
- Arbitration (combinational, same cycle): search eligible channels starting at index ptr, wrapping modulo N_CH. Grant the first one found. At most one bit of req_ready is set. req_ready has no dependence on req_sym.
- On a grant to channel g: ptr <= (g+1) mod N_CH at the posedge. With no grant, ptr holds.
- ctx_clr[i]=1: state[i] <= 0 at the posedge. Channel i is not granted that cycle, so its symbol stays pending. Several clears in one cycle are all applied.
- Transition for the granted channel, s = state[g], y = symbol:
  - y=0: hold s.
  - y=1: next=1.
  - y=2: s=1 -> 2; s=2 -> 2; s in {0,3} -> 0.
  - y=3: s=2 -> 3; s=3 -> 3; s in {0,1} -> 0.
- Non-granted, non-cleared channels hold their state.
- match[i] = (state[i]==3), driven from the registered state, so it updates one cycle after the consuming handshake.
- Hit condition: granted transition with s!=3 and next==3.
  - At the posedge: hit <= 1; hit_ch <= g; hit_total <= hit_total+1, wrapping from 2^CNT_W-1 to 0.
  - Otherwise hit <= 0; hit_ch holds its last value; hit_total holds.
  - Latency: hit is high exactly one cycle, in the cycle after the handshake of the completing 3.
  - A 3 applied while s==3 produces no hit.
- Reset mid-stream: reset wins over grant, clear and hit update. Any handshake coinciding with reset_n=0 is not performed (ready is 0).

Decomposition:
- Shared package: symbol encodings SYM_NOP=0, SYM_A=1, SYM_B=2, SYM_C=3; state encodings ST_IDLE=0, ST_A=1, ST_AB=2, ST_ABC=3; and a pure function next_state(s, y) implementing the transition above.
- One natural sub-module, rr_arbiter: N_CH requests plus ptr in, one-hot grant and encoded index out, purely combinational.
- The scheduler top holds ptr, the per-channel state array, and the hit/count registers.

Test Plan:
- Channel 0 only, symbols 1,2,1,2,3,3,1 on consecutive cycles:
  - state[0] sequence 1,2,1,2,3,3,1;
  - hit=1 with hit_ch=0 only in the cycle after the first 3;
  - second 3 gives no hit;
  - match[0]=1 for two cycles, then 0 after the 1;
  - hit_total=1.
- Channels 0..3 all valid every cycle, each streaming 1,2,3:
  - grants rotate 0,1,2,3,0,...;
  - each channel completes on its third grant;
  - hits arrive with hit_ch 0,1,2,3 on consecutive cycles;
  - hit_total=4.
- Channels 1 and 3 valid, ptr=2:
  - first grant goes to 3, next to 1;
  - an idle channel never receives ready.
- Channel 2 at state 2, symbol 3 valid, with ctx_clr[2]=1 in the same cycle:
  - req_ready[2]=0 and state[2]=0;
  - next cycle symbol 3 is granted -> state 0, no hit.
- Drive 256 completed sequences on channel 1:
  - hit_total wraps to 0 after the 256th hit, with CNT_W=8.
- Channel 0 at state 2 plus pending 3, reset_n=0 for one cycle:
  - ready=0 and no hit;
  - all states, match and hit_total read 0;
  - after release, ptr=0 arbitration resumes from channel 0.
